// File: rtl/mult_err_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_accum_if
// Brief    : Sample stream (operands, approximate product, handshake) into the
//            error-metric accumulator.
// Revision : 1.0
// ============================================================================
interface mult_err_accum_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2*N-1:0]   p_approx;
    logic             last;

    modport master (
        output in_valid, a, b, p_approx, last,
        input  in_ready
    );

    modport slave (
        input  in_valid, a, b, p_approx, last,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mult_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : mult_err_accum
// Brief    : Three-stage pipeline measuring the error distance of an
//            approximate multiplier and accumulating saturating totals.
// Revision : 1.0
// ============================================================================
module mult_err_accum #(
    parameter int N     = 8,
    parameter int CNT_W = 17,
    parameter int SUM_W = 32,
    parameter int SQ_W  = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    mult_err_accum_if.slave    smp,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   sample_count_o,
    output logic [CNT_W-1:0]   mismatch_count_o,
    output logic [SUM_W-1:0]   sum_ed_o,
    output logic [SQ_W-1:0]    sum_sq_ed_o,
    output logic [2*N-1:0]     max_ed_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   drain_cnt_q, drain_cnt_d;

    logic   accept;
    logic   clear;

    logic             v1_q;
    logic [2*N-1:0]   exact_q;
    logic [2*N-1:0]   papx_q;
    logic             v2_q;
    logic [2*N-1:0]   ed_q;
    logic [4*N-1:0]   sq_q;
    logic             mis_q;

    logic [2*N-1:0]   exact_w;
    logic [2*N-1:0]   ed_w;
    logic [4*N-1:0]   sq_w;

    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
    logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
    logic [SQ_W-1:0]  sum_sq_q, sum_sq_d;
    logic [2*N-1:0]   max_ed_q, max_ed_d;

    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W:0]   mis_sum;
    logic [SUM_W:0]   ed_sum;
    logic [SQ_W:0]    sq_sum;

    assign accept = smp.in_valid && (state_q == S_RUN);
    assign clear  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    // ------------------------------------------------------------------------
    // Session control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // DRAIN spans two cycles so the final sample clears S2 and S3 before DONE.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (accept && smp.last) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = start_i ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign smp.in_ready = (state_q == S_RUN);
    assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o       = (state_q == S_DONE);

    // ------------------------------------------------------------------------
    // Datapath: S1 exact product, S2 error distance, S3 accumulate
    // ------------------------------------------------------------------------
    assign exact_w = (2*N)'(smp.a) * (2*N)'(smp.b);
    assign ed_w    = (papx_q >= exact_q) ? (papx_q - exact_q) : (exact_q - papx_q);
    assign sq_w    = (4*N)'(ed_w) * (4*N)'(ed_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            exact_q <= '0;
            papx_q  <= '0;
            v2_q    <= 1'b0;
            ed_q    <= '0;
            sq_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                exact_q <= exact_w;
                papx_q  <= smp.p_approx;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                ed_q  <= ed_w;
                sq_q  <= sq_w;
                mis_q <= (ed_w != '0);
            end
        end
    end

    // One extra carry bit per sum flags overflow, which pins the total at all-ones.
    assign cnt_sum = {1'b0, sample_count_q}   + (CNT_W+1)'(1);
    assign mis_sum = {1'b0, mismatch_count_q} + (CNT_W+1)'(mis_q);
    assign ed_sum  = {1'b0, sum_ed_q}         + (SUM_W+1)'(ed_q);
    assign sq_sum  = {1'b0, sum_sq_q}         + (SQ_W+1)'(sq_q);

    always_comb begin
        sample_count_d   = sample_count_q;
        mismatch_count_d = mismatch_count_q;
        sum_ed_d         = sum_ed_q;
        sum_sq_d         = sum_sq_q;
        max_ed_d         = max_ed_q;
        if (clear) begin
            sample_count_d   = '0;
            mismatch_count_d = '0;
            sum_ed_d         = '0;
            sum_sq_d         = '0;
            max_ed_d         = '0;
        end else if (v2_q) begin
            sample_count_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            mismatch_count_d = mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
            sum_ed_d         = ed_sum[SUM_W]  ? '1 : ed_sum[SUM_W-1:0];
            sum_sq_d         = sq_sum[SQ_W]   ? '1 : sq_sum[SQ_W-1:0];
            if (ed_q > max_ed_q) max_ed_d = ed_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count_q   <= '0;
            mismatch_count_q <= '0;
            sum_ed_q         <= '0;
            sum_sq_q         <= '0;
            max_ed_q         <= '0;
        end else begin
            sample_count_q   <= sample_count_d;
            mismatch_count_q <= mismatch_count_d;
            sum_ed_q         <= sum_ed_d;
            sum_sq_q         <= sum_sq_d;
            max_ed_q         <= max_ed_d;
        end
    end

    assign sample_count_o   = sample_count_q;
    assign mismatch_count_o = mismatch_count_q;
    assign sum_ed_o         = sum_ed_q;
    assign sum_sq_ed_o      = sum_sq_q;
    assign max_ed_o         = max_ed_q;

endmodule
`default_nettype wire
